// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle collision controller.
package game_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned DIFF_W  = 11;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned LIVES_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  // Unsigned |a-b|, widened so no magnitude is lost.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (DIFF_W'(a) - DIFF_W'(b)) : (DIFF_W'(b) - DIFF_W'(a));
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Axis-aligned box overlap test on center + half-extent geometry.
module aabb_overlap
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] as,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] bs,
  output logic               hit
);

  logic [DIFF_W-1:0] dx;
  logic [DIFF_W-1:0] dy;
  logic [DIFF_W-1:0] reach;

  // Sum of half-extents is exact in 11 bits; touching edges do not overlap.
  assign dx    = abs_diff(ax, bx);
  assign dy    = abs_diff(ay, by);
  assign reach = DIFF_W'(as) + DIFF_W'(bs);
  assign hit   = (dx < reach) && (dy < reach);

endmodule

// File: rtl/obstacle_collision_ctrl.sv
// Per-frame player/obstacle collision, hit debouncing, lives and score tracking.
module obstacle_collision_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_OBS       = 4,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned SCORE_W       = 16
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic                       game_start,
  input  logic [COORD_W-1:0]         player_x,
  input  logic [COORD_W-1:0]         player_y,
  input  logic [COORD_W-1:0]         player_size,
  input  logic [COORD_W*NUM_OBS-1:0] obs_x,
  input  logic [COORD_W*NUM_OBS-1:0] obs_y,
  input  logic [COORD_W*NUM_OBS-1:0] obs_size,
  input  logic [NUM_OBS-1:0]         obs_active,
  output logic                       hit_pulse,
  output logic [IDX_W-1:0]           hit_index,
  output logic [LIVES_W-1:0]         lives,
  output logic                       invuln,
  output logic                       game_over,
  output logic [SCORE_W-1:0]         score,
  output logic [1:0]                 state
);

  localparam int unsigned CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   INV_LOAD  = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

  game_state_t         state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d, score_inc;
  logic [CNT_W-1:0]    inv_cnt_q, inv_cnt_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic [IDX_W-1:0]    hit_index_q, hit_index_d;
  logic                invuln_q, invuln_d;
  logic                game_over_q, game_over_d;

  logic [NUM_OBS-1:0]  raw_hit;
  logic [NUM_OBS-1:0]  overlap;
  logic                any_hit;
  logic [IDX_W-1:0]    sel;

  // One overlap checker per obstacle, gated by its active flag.
  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
    aabb_overlap u_aabb (
      .ax  (player_x),
      .ay  (player_y),
      .as  (player_size),
      .bx  (obs_x[COORD_W*g +: COORD_W]),
      .by  (obs_y[COORD_W*g +: COORD_W]),
      .bs  (obs_size[COORD_W*g +: COORD_W]),
      .hit (raw_hit[g])
    );
  end

  assign overlap = raw_hit & obs_active;
  assign any_hit = |overlap;

  // Fixed-priority encoder: lowest overlapping index wins.
  always_comb begin
    sel = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (overlap[i]) sel = IDX_W'(i);
    end
  end

  assign score_inc = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

  // Next-state and registered-output logic for the game FSM.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    score_d     = score_q;
    inv_cnt_d   = inv_cnt_q;
    hit_pulse_d = 1'b0;
    hit_index_d = hit_index_q;
    case (state_q)
      IDLE: begin
        lives_d = LIVES_RST;
        score_d = '0;
        if (game_start) state_d = PLAY;
      end
      PLAY: begin
        score_d = score_inc;
        if (any_hit) begin
          hit_pulse_d = 1'b1;
          hit_index_d = sel;
          lives_d     = lives_q - LIVES_W'(1);
          if (lives_q <= LIVES_W'(1)) begin
            state_d = GAME_OVER;
          end else begin
            state_d   = INVULN;
            inv_cnt_d = INV_LOAD;
          end
        end
      end
      INVULN: begin
        score_d = score_inc;
        if (inv_cnt_q == '0) state_d = PLAY;
        else inv_cnt_d = inv_cnt_q - CNT_W'(1);
      end
      GAME_OVER: begin
        if (game_start) begin
          state_d = PLAY;
          lives_d = LIVES_RST;
          score_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == GAME_OVER);
  end

  // State and output registers, synchronous active-high reset.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      lives_q     <= LIVES_RST;
      score_q     <= '0;
      inv_cnt_q   <= '0;
      hit_pulse_q <= 1'b0;
      hit_index_q <= '0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      inv_cnt_q   <= inv_cnt_d;
      hit_pulse_q <= hit_pulse_d;
      hit_index_q <= hit_index_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign hit_pulse = hit_pulse_q;
  assign hit_index = hit_index_q;
  assign lives     = lives_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;
  assign score     = score_q;
  assign state     = 2'(state_q);

endmodule

// File: tb/tb_obstacle_collision_ctrl.sv
// Directed self-checking bench for obstacle_collision_ctrl.
module tb_obstacle_collision_ctrl;

  localparam int NOBS = 4;

  logic             frame_clk = 1'b0;
  logic             Reset;
  logic             game_start;
  logic [9:0]       player_x, player_y, player_size;
  logic [10*NOBS-1:0] obs_x, obs_y, obs_size;
  logic [NOBS-1:0]  obs_active;
  logic             hit_pulse;
  logic [2:0]       hit_index;
  logic [2:0]       lives;
  logic             invuln;
  logic             game_over;
  logic [15:0]      score;
  logic [1:0]       state;

  int n_assert = 0;
  int n_fail   = 0;

  obstacle_collision_ctrl #(
    .NUM_OBS(NOBS), .LIVES_INIT(3), .INVULN_FRAMES(60), .SCORE_W(16)
  ) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .game_start  (game_start),
    .player_x    (player_x),
    .player_y    (player_y),
    .player_size (player_size),
    .obs_x       (obs_x),
    .obs_y       (obs_y),
    .obs_size    (obs_size),
    .obs_active  (obs_active),
    .hit_pulse   (hit_pulse),
    .hit_index   (hit_index),
    .lives       (lives),
    .invuln      (invuln),
    .game_over   (game_over),
    .score       (score),
    .state       (state)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("%s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one frame; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_obs(input int i, input int x, input int y, input int s, input logic act);
    obs_x[10*i +: 10]    = 10'(x);
    obs_y[10*i +: 10]    = 10'(y);
    obs_size[10*i +: 10] = 10'(s);
    obs_active[i]        = act;
  endtask

  initial begin
    int inv_frames;
    int gap;

    Reset       = 1'b1;
    game_start  = 1'b0;
    player_x    = 10'd100;
    player_y    = 10'd100;
    player_size = 10'd8;
    obs_x = '0; obs_y = '0; obs_size = '0; obs_active = '0;
    for (int i = 0; i < NOBS; i++) set_obs(i, 500, 500, 8, 1'b0);

    // Reset state
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_pulse", hit_pulse, 0);
    chk("rst_index", hit_index, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_gover", game_over, 0);

    Reset = 1'b0;
    step();
    chk("idle_hold", state, 0);

    // Start: PLAY, score counts per frame
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    step(); step(); step();
    chk("score_count", score, 3);

    // Touching boundary: |dx|=16 is not < 16; inactive fully-overlapping obstacle never hits
    set_obs(0, 116, 100, 8, 1'b1);
    set_obs(2, 100, 100, 8, 1'b0);
    step();
    chk("edge_nohit", hit_pulse, 0);
    chk("edge_state", state, 1);
    chk("edge_score", score, 4);

    // |dx|=15 overlaps
    set_obs(0, 115, 100, 8, 1'b1);
    step();
    set_obs(0, 500, 500, 8, 1'b0);
    chk("hit1_pulse", hit_pulse, 1);
    chk("hit1_index", hit_index, 0);
    chk("hit1_lives", lives, 2);
    chk("hit1_state", state, 2);
    chk("hit1_score", score, 5);
    inv_frames = (invuln === 1'b1) ? 1 : 0;
    step();
    chk("pulse_one_frame", hit_pulse, 0);
    if (invuln === 1'b1) inv_frames++;
    for (int k = 0; k < 58; k++) begin
      step();
      if (invuln === 1'b1) inv_frames++;
    end
    step();
    chk("inv_end_invuln", invuln, 0);
    chk("inv_end_state", state, 1);
    chk("inv_frame_count", inv_frames, 60);
    chk("inv_end_score", score, 65);

    // Two overlaps: lowest index wins, single decrement
    set_obs(1, 105, 100, 8, 1'b1);
    set_obs(3, 95, 100, 8, 1'b1);
    step();
    set_obs(1, 500, 500, 8, 1'b0);
    set_obs(3, 500, 500, 8, 1'b0);
    chk("prio_pulse", hit_pulse, 1);
    chk("prio_index", hit_index, 1);
    chk("prio_lives", lives, 1);
    step();
    chk("prio_single", hit_pulse, 0);
    chk("prio_lives2", lives, 1);

    // Reset during INVULN with an active overlap present
    set_obs(0, 100, 100, 8, 1'b1);
    Reset = 1'b1;
    step();
    chk("midrst_state", state, 0);
    chk("midrst_invuln", invuln, 0);
    chk("midrst_lives", lives, 3);
    chk("midrst_score", score, 0);
    chk("midrst_pulse", hit_pulse, 0);
    Reset = 1'b0;

    // Overlap on the IDLE->PLAY edge is not counted
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("go_state", state, 1);
    chk("go_nohit", hit_pulse, 0);
    chk("go_lives", lives, 3);

    // Persistent overlap: hits 61 frames apart until game over
    step();
    chk("p1_pulse", hit_pulse, 1);
    chk("p1_lives", lives, 2);
    gap = 999;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (hit_pulse === 1'b1) begin gap = k; break; end
    end
    chk("p2_gap", gap, 61);
    chk("p2_lives", lives, 1);
    gap = 999;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (hit_pulse === 1'b1) begin gap = k; break; end
    end
    chk("p3_gap", gap, 61);
    chk("p3_lives", lives, 0);
    chk("p3_gover", game_over, 1);
    chk("p3_state", state, 3);
    chk("p3_score", score, 123);
    step(); step(); step();
    chk("frozen_score", score, 123);
    chk("frozen_lives", lives, 0);
    chk("frozen_pulse", hit_pulse, 0);

    // Restart from GAME_OVER
    set_obs(0, 500, 500, 8, 1'b0);
    game_start = 1'b1;
    step();
    chk("restart_state", state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_gover", game_over, 0);
    step();
    game_start = 1'b0;
    chk("held_start_play", state, 1);
    chk("held_start_score", score, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
